// File: rtl/uart_pkg.sv
// Shared UART definitions: register offsets, LCR field positions, transmit FSM states
// and the transmit parity helper.
package uart_pkg;

  localparam logic [2:0] UART_DLL_RBR = 3'd0;
  localparam logic [2:0] UART_IER     = 3'd1;
  localparam logic [2:0] UART_IIR_FCR = 3'd2;
  localparam logic [2:0] UART_LCR     = 3'd3;
  localparam logic [2:0] UART_MCR     = 3'd4;
  localparam logic [2:0] UART_LSR     = 3'd5;
  localparam logic [2:0] UART_MSR     = 3'd6;
  localparam logic [2:0] UART_SCR     = 3'd7;

  localparam int LCR_WLS0  = 0;
  localparam int LCR_WLS1  = 1;
  localparam int LCR_STB   = 2;
  localparam int LCR_PEN   = 3;
  localparam int LCR_EPS   = 4;
  localparam int LCR_STICK = 5;
  localparam int LCR_BRK   = 6;
  localparam int LCR_DLAB  = 7;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;

  // Parity over the transmitted bits only; stick parity sends the inverse of EPS.
  function automatic logic tx_parity(input logic [7:0] d, input logic [1:0] wls,
                                     input logic eps, input logic stick);
    logic [7:0] m;
    m = d & (8'hFF >> (2'd3 - wls));
    return stick ? ~eps : (eps ? ^m : ~^m);
  endfunction

endpackage

// File: rtl/uart_baudgen.sv
// Baud tick generator: divisor * 2^PRESCALE clock period, divisor 0 behaves as 1.
// load_i restarts the period so a new character begins on a clean bit boundary.
module uart_baudgen #(
  parameter int PRESCALE = 0
) (
  input  logic        gclk,
  input  logic        grst_n,
  input  logic        load_i,
  input  logic [15:0] divisor_i,
  output logic        tick_o
);
  localparam int CW = 16 + PRESCALE;

  logic [CW-1:0] cnt_q, cnt_d, reload;
  logic [15:0]   div_eff;

  assign div_eff = (divisor_i == 16'd0) ? 16'd1 : divisor_i;
  assign reload  = (CW'(div_eff) << PRESCALE) - CW'(1);
  assign tick_o  = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - CW'(1);
    if (load_i || cnt_q == '0) cnt_d = reload;
  end

  always_ff @(posedge gclk) begin
    if (!grst_n) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 16550-style transmitter: TX FIFO (or 1-entry THR), frame serializer and status flags.
// Optional CTS flow control with UART_TX_CTS_FLOW_EN (holds off new characters while CTSb=1).
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int UART_PRESCALE = 0,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic       TxWrite,
  input  logic [7:0] TxData,
  input  logic [7:0] DLL,
  input  logic [7:0] DLM,
  input  logic [7:0] LCR,
  input  logic       FifoEn,
  input  logic       TxFifoReset,
  input  logic       CTSb,
  output logic       SOUT,
  output logic       THRE,
  output logic       TEMT,
  output logic       TXRDYb,
  output logic [4:0] TxFifoCount
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]    cnt_q, cnt_d, cap;
  logic          fifo_en_q, flush, wr_acc, pop, cts_ok, unused_ok;
  logic          tick, bit_done, stop_done, idle_nxt;
  logic          thre_q, temt_q, txrdyb_q;

  tx_state_t     state_q;
  logic [7:0]    shift_q;
  logic [1:0]    wls_q;
  logic          pen_q, stb_q, par_q, line_q, brk_q;
  logic [2:0]    bit_q;
  logic [3:0]    tcnt_q;

`ifdef UART_TX_CTS_FLOW_EN
  assign cts_ok    = ~CTSb;
  assign unused_ok = LCR[LCR_DLAB];
`else
  assign cts_ok    = 1'b1;
  assign unused_ok = ^{CTSb, LCR[LCR_DLAB]};
`endif

  assign cap       = FifoEn ? 5'(FIFO_DEPTH) : 5'd1;
  assign flush     = TxFifoReset | (FifoEn != fifo_en_q);
  assign wr_acc    = TxWrite & ~flush & (cnt_q < cap);
  assign bit_done  = tick & (tcnt_q == 4'hF);
  assign stop_done = (state_q == STOP) & bit_done & (bit_q == {2'b00, stb_q});
  // A new character is taken either from idle or straight out of the last stop bit.
  assign pop       = (cnt_q != 5'd0) & cts_ok & ((state_q == IDLE) | stop_done);
  assign idle_nxt  = ((state_q == IDLE) | stop_done) & ~pop;

  always_comb begin
    cnt_d = cnt_q;
    if (flush) cnt_d = '0;
    else       cnt_d = cnt_q + 5'(wr_acc) - 5'(pop);
  end

  uart_baudgen #(.PRESCALE(UART_PRESCALE)) u_baud (
    .gclk      (PCLK),
    .grst_n    (PRESETn),
    .load_i    (pop),
    .divisor_i ({DLM, DLL}),
    .tick_o    (tick)
  );

  always_ff @(posedge PCLK) begin
    if (wr_acc) mem_q[wr_ptr_q] <= TxData;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      fifo_en_q <= FifoEn;
      thre_q    <= 1'b1;
      temt_q    <= 1'b1;
      txrdyb_q  <= 1'b0;
    end else begin
      fifo_en_q <= FifoEn;
      cnt_q     <= cnt_d;
      thre_q    <= (cnt_d == 5'd0);
      temt_q    <= (cnt_d == 5'd0) & idle_nxt;
      txrdyb_q  <= (cnt_d >= cap);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      shift_q <= '0;
      wls_q   <= '0;
      pen_q   <= 1'b0;
      stb_q   <= 1'b0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      tcnt_q  <= '0;
      line_q  <= 1'b1;
      brk_q   <= 1'b0;
    end else begin
      brk_q <= LCR[LCR_BRK];
      if (tick) tcnt_q <= tcnt_q + 4'd1;
      if (pop) begin
        state_q <= START;
        shift_q <= mem_q[rd_ptr_q];
        wls_q   <= LCR[LCR_WLS1:LCR_WLS0];
        stb_q   <= LCR[LCR_STB];
        pen_q   <= LCR[LCR_PEN];
        par_q   <= tx_parity(mem_q[rd_ptr_q], LCR[LCR_WLS1:LCR_WLS0], LCR[LCR_EPS], LCR[LCR_STICK]);
        tcnt_q  <= '0;
        bit_q   <= '0;
        line_q  <= 1'b0;
      end else if (bit_done) begin
        unique case (state_q)
          START: begin
            state_q <= DATA;
            line_q  <= shift_q[0];
            shift_q <= shift_q >> 1;
            bit_q   <= '0;
          end
          DATA: begin
            if (bit_q == 3'd4 + {1'b0, wls_q}) begin
              state_q <= pen_q ? PARITY : STOP;
              line_q  <= pen_q ? par_q : 1'b1;
              bit_q   <= '0;
            end else begin
              bit_q   <= bit_q + 3'd1;
              line_q  <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
          PARITY: begin
            state_q <= STOP;
            line_q  <= 1'b1;
            bit_q   <= '0;
          end
          STOP: begin
            if (bit_q == {2'b00, stb_q}) begin
              state_q <= IDLE;
              line_q  <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign SOUT        = line_q & ~brk_q;
  assign THRE        = thre_q;
  assign TEMT        = temt_q;
  assign TXRDYb      = txrdyb_q;
  assign TxFifoCount = cnt_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench: expected SOUT is a per-cycle waveform queue built from frame rules.
module tb_uart_tx_serializer;

  logic       PCLK = 1'b0;
  logic       PRESETn, TxWrite, FifoEn, TxFifoReset, CTSb;
  logic [7:0] TxData, DLL, DLM, LCR;
  logic       SOUT, THRE, TEMT, TXRDYb;
  logic [4:0] TxFifoCount;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];

  uart_tx_serializer dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .TxWrite(TxWrite), .TxData(TxData),
    .DLL(DLL), .DLM(DLM), .LCR(LCR), .FifoEn(FifoEn), .TxFifoReset(TxFifoReset),
    .CTSb(CTSb), .SOUT(SOUT), .THRE(THRE), .TEMT(TEMT), .TXRDYb(TXRDYb),
    .TxFifoCount(TxFifoCount)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Frame = start 0, 5+WLS data bits LSB first, optional parity, 1 or 2 stop bits,
  // each bit held for 16 baud ticks of max(divisor,1) cycles.
  task automatic push_frame(input logic [7:0] b, input logic [7:0] l, input int dv);
    int n;
    int wl;
    bit ones;
    bit fr[$];
    n    = 16 * ((dv == 0) ? 1 : dv);
    wl   = 5 + int'(l[1:0]);
    ones = 1'b0;
    fr.push_back(1'b0);
    for (int i = 0; i < wl; i++) begin
      fr.push_back(b[i]);
      ones ^= b[i];
    end
    if (l[3]) fr.push_back(l[5] ? !l[4] : (l[4] ? ones : !ones));
    fr.push_back(1'b1);
    if (l[2]) fr.push_back(1'b1);
    foreach (fr[i]) repeat (n) exp_q.push_back(fr[i]);
  endtask

  // One clock; SOUT checked at the falling edge against the model (idle high, break low).
  task automatic cyc(input string tag);
    bit e;
    @(posedge PCLK);
    @(negedge PCLK);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'b1;
    if (LCR[6]) e = 1'b0;
    chk(tag, 32'(SOUT), 32'(e));
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) cyc(tag);
  endtask

  task automatic one_char(input logic [7:0] b, input logic [7:0] l, input int dv,
                          input int bon, input int boff);
    int len;
    LCR = l;
    {DLM, DLL} = 16'(dv);
    exp_q.push_back(1'b1);
    push_frame(b, l, dv);
    len = exp_q.size() - 1;
    TxData  = b;
    TxWrite = 1'b1;
    cyc("sout");
    TxWrite = 1'b0;
    chk("thre_after_wr", 32'(THRE), 32'd0);
    chk("temt_after_wr", 32'(TEMT), 32'd0);
    for (int k = 1; k <= len + 1; k++) begin
      if (k == bon)  LCR[6] = 1'b1;
      if (k == boff) LCR[6] = 1'b0;
      cyc("sout");
      chk("temt", 32'(TEMT), 32'(k > len));
      chk("thre", 32'(THRE), 32'd1);
    end
  endtask

  initial begin
    logic [7:0] data [20];
    logic [7:0] a, b;

    PRESETn = 1'b0; TxWrite = 1'b0; TxData = '0; FifoEn = 1'b1;
    TxFifoReset = 1'b0; CTSb = 1'b0; LCR = 8'h03; DLL = 8'd1; DLM = 8'd0;
    cyc("rst_sout");
    cyc("rst_sout");
    chk("rst_thre", 32'(THRE), 32'd1);
    chk("rst_temt", 32'(TEMT), 32'd1);
    chk("rst_txrdyb", 32'(TXRDYb), 32'd0);
    chk("rst_cnt", 32'(TxFifoCount), 32'd0);
    PRESETn = 1'b1;
    cyc("idle_sout");

    // Directed frames: 8N1, parity variants, 5-bit with 2 stops, divisor 0, break.
    one_char(8'h55, 8'h03, 1, 0, 0);
    one_char(8'h01, 8'h1B, 1, 0, 0);
    one_char(8'h01, 8'h0B, 1, 0, 0);
    one_char(8'h01, 8'h3B, 1, 0, 0);
    one_char(8'h1F, 8'h04, 1, 0, 0);
    one_char(8'hA3, 8'h03, 0, 0, 0);
    one_char(8'h1F, 8'h04, 1, 40, 70);

    for (int r = 0; r < 12; r++)
      one_char(8'($urandom), 8'($urandom_range(0, 63)), int'($urandom_range(0, 3)), 0, 0);

    // 17 consecutive writes: first pops at once, count peaks at 16, stream is gapless.
    LCR = 8'h03; {DLM, DLL} = 16'd1;
    exp_q.push_back(1'b1);
    for (int i = 0; i < 17; i++) begin
      data[i] = 8'($urandom);
      push_frame(data[i], 8'h03, 1);
    end
    for (int i = 0; i < 17; i++) begin
      TxData = data[i]; TxWrite = 1'b1;
      cyc("burst_sout");
      chk("burst_cnt", 32'(TxFifoCount), (i == 0) ? 32'd1 : 32'(i));
      chk("burst_txrdyb", 32'(TXRDYb), 32'(i == 16));
    end
    TxWrite = 1'b0;
    drain("burst_sout");
    cyc("burst_sout");
    chk("burst_temt", 32'(TEMT), 32'd1);
    chk("burst_cnt_end", 32'(TxFifoCount), 32'd0);

    // 20 writes at a slow baud: overflow drops, then flush mid-character.
    {DLM, DLL} = 16'd8;
    data[0] = 8'($urandom);
    exp_q.push_back(1'b1);
    push_frame(data[0], 8'h03, 8);
    for (int i = 0; i < 20; i++) begin
      TxData = (i == 0) ? data[0] : 8'($urandom); TxWrite = 1'b1;
      cyc("drop_sout");
      chk("drop_cnt", 32'(TxFifoCount), (i == 0) ? 32'd1 : ((i > 16) ? 32'd16 : 32'(i)));
    end
    TxWrite = 1'b0;
    chk("drop_txrdyb", 32'(TXRDYb), 32'd1);
    repeat (100) cyc("drop_sout");
    TxFifoReset = 1'b1;
    cyc("flush_sout");
    TxFifoReset = 1'b0;
    chk("flush_cnt", 32'(TxFifoCount), 32'd0);
    chk("flush_thre", 32'(THRE), 32'd1);
    chk("flush_txrdyb", 32'(TXRDYb), 32'd0);
    chk("flush_temt", 32'(TEMT), 32'd0);
    drain("flush_sout");
    repeat (40) cyc("flush_idle");
    chk("flush_temt_end", 32'(TEMT), 32'd1);

    // 1-entry THR mode: third write lands while full and is lost.
    FifoEn = 1'b0; {DLM, DLL} = 16'd1;
    cyc("thr_sout");
    a = 8'($urandom); b = 8'($urandom);
    exp_q.push_back(1'b1);
    push_frame(a, 8'h03, 1);
    push_frame(b, 8'h03, 1);
    TxData = a; TxWrite = 1'b1; cyc("thr_sout");
    TxWrite = 1'b0;            cyc("thr_sout");
    chk("thr_cnt_pop", 32'(TxFifoCount), 32'd0);
    TxData = b; TxWrite = 1'b1; cyc("thr_sout");
    TxData = 8'($urandom);      cyc("thr_sout");
    TxWrite = 1'b0;
    chk("thr_cnt_full", 32'(TxFifoCount), 32'd1);
    chk("thr_txrdyb", 32'(TXRDYb), 32'd1);
    drain("thr_sout");
    cyc("thr_sout");
    chk("thr_temt", 32'(TEMT), 32'd1);

    // LCR written mid-character only affects the following character.
    FifoEn = 1'b1;
    cyc("lcr_sout");
    a = 8'($urandom); b = 8'($urandom);
    exp_q.push_back(1'b1);
    push_frame(a, 8'h03, 1);
    push_frame(b, 8'h1F, 1);
    TxData = a; TxWrite = 1'b1; cyc("lcr_sout");
    TxData = b;                 cyc("lcr_sout");
    TxWrite = 1'b0;
    chk("lcr_cnt", 32'(TxFifoCount), 32'd1);
    repeat (20) cyc("lcr_sout");
    LCR = 8'h1F;
    drain("lcr_sout");
    cyc("lcr_sout");
    LCR = 8'h03;

    // Reset mid-character aborts the frame immediately.
    exp_q.push_back(1'b1);
    push_frame(8'h00, 8'h03, 1);
    TxData = 8'h00; TxWrite = 1'b1; cyc("rstmid_sout");
    TxWrite = 1'b0;
    repeat (30) cyc("rstmid_sout");
    exp_q.delete();
    PRESETn = 1'b0;
    cyc("rstmid_sout");
    chk("rstmid_cnt", 32'(TxFifoCount), 32'd0);
    chk("rstmid_temt", 32'(TEMT), 32'd1);
    chk("rstmid_thre", 32'(THRE), 32'd1);
    PRESETn = 1'b1;
    cyc("rstmid_sout");
    one_char(8'hC6, 8'h03, 2, 0, 0);

`ifdef UART_TX_CTS_FLOW_EN
    CTSb = 1'b1;
    TxData = 8'hA5; TxWrite = 1'b1; cyc("cts_sout");
    TxWrite = 1'b0;
    repeat (6) begin
      cyc("cts_hold_sout");
      chk("cts_hold_temt", 32'(TEMT), 32'd0);
    end
    CTSb = 1'b0;
    push_frame(8'hA5, 8'h03, 2);
    drain("cts_sout");
    cyc("cts_sout");
    chk("cts_temt", 32'(TEMT), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit half of the PC16550D-compatible UART. Accepts bytes written to THR (offset 0, DLAB=0) by the register block.
- Buffers them in a 16-entry TX FIFO, or a 1-entry THR when FIFOs are disabled.
- Serializes each byte onto SOUT at the programmed baud, word length, parity and stop bits.
- Reports THRE, TEMT and TXRDYb back to the register block for LSR and the ready pins.

Parameters:
- UART_PRESCALE, 0: extra log2 clock divide; baud tick period = {DLM,DLL} * 2^UART_PRESCALE PCLK cycles.
- FIFO_DEPTH, 16: TX FIFO entries; must be a power of 2.

Ports:
- PCLK  in  1  UART clock; all state updates on rising edge.
- PRESETn  in  1  reset; synchronous, active-low.
- TxWrite  in  1  one-cycle pulse: write TxData to THR/FIFO.
- TxData  in  8  byte to transmit.
- DLL  in  8  divisor latch low.
- DLM  in  8  divisor latch high.
- LCR  in  8  [1:0] WLS, [2] STB, [3] PEN, [4] EPS, [5] stick parity, [6] break.
- FifoEn  in  1  FCR[0]; 0 selects 1-entry THR mode.
- TxFifoReset  in  1  FCR[2] pulse; flushes the FIFO.
- CTSb  in  1  synchronized clear-to-send, active-low; used only with the flow-control option.
- SOUT  out  1  serial output; idle high.
- THRE  out  1  THR/FIFO empty.
- TEMT  out  1  FIFO empty and shifter idle.
- TXRDYb  out  1  low when another write is accepted.
- TxFifoCount  out  5  current occupancy, 0..16.

Behaviour:
- Reset values: SOUT=1, THRE=1, TEMT=1, TXRDYb=0, TxFifoCount=0, FSM=IDLE. FIFO pointers and the baud counter are cleared.
- Reset mid-character aborts the character immediately; SOUT=1 on the next cycle.
- Baud generator:
  - Down-counter reloads with divisor*2^UART_PRESCALE and emits a 1-cycle tick at terminal count.
  - Divisor 0 is treated as 1.
  - The counter is reset whenever a character is loaded, so every bit is exactly 16 ticks.
- FIFO:
  - Capacity is FIFO_DEPTH when FifoEn=1, else 1.
  - A write when full is dropped; count and contents are unchanged.
  - A simultaneous write and pop keeps the count; pointers wrap modulo depth.
  - TxFifoReset empties the FIFO in 1 cycle and does not abort the character in the shifter.
  - A FifoEn change also flushes the FIFO.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, or STOP -> START back-to-back if the FIFO is non-empty.
- IDLE with FIFO non-empty: the next edge pops the head into the shifter, latches LCR, enters START and drives SOUT=0.
- LCR changes mid-character take effect on the next character.
- Data phase:
  - Bits go out LSB first.
  - Word length = 5+WLS.
  - Bits above the word length are ignored.
- Parity (PEN=1):
  - EPS=1 gives even parity, EPS=0 odd.
  - Stick parity (LCR[5]=1) forces the parity bit to ~EPS.
- Stop bits:
  - STB=0: 1 stop bit.
  - STB=1: 2 stop bits, including 5-bit words (deliberate: 2, not 1.5).
- Break (LCR[6]=1): SOUT forced to 0. FSM timing continues unaffected, and SOUT returns to the shifter value when break clears.
- Status outputs:
  - THRE = (count==0).
  - TEMT = THRE & FSM==IDLE.
  - TXRDYb = 1 when full, otherwise 0.
  - All are registered, so they update the cycle after the causing edge.
- Latency: first start-bit edge on SOUT is 2 cycles after the TxWrite edge when idle.

Optional Feature:
- Macro: UART_TX_CTS_FLOW_EN.
- Defined: IDLE does not pop/start while CTSb=1. A character already started always completes. Deasserting CTSb lets the next character start on the following cycle.
- Undefined: CTSb is ignored (port still present, unused).

Decomposition:
- Shared package uart_pkg:
  - Register offset constants UART_DLL_RBR..UART_SCR.
  - LCR field bit-index constants.
  - typedef enum tx_state_t {IDLE, START, DATA, PARITY, STOP}.
- One sub-module, uart_baudgen: the divisor/prescale tick counter with a load-reset input. It is reused later by the receiver.
- The FIFO is inline (pointer + count).

Test Plan:
- Divisor=1, P=0, LCR=0x03, write 0x55:
  - SOUT=0 for 16 cycles, then 1,0,1,0,1,0,1,0 at 16 cycles each, then stop=1 for 16 cycles.
  - TEMT high 160 cycles after the start edge.
- LCR=0x1B (8E1), write 0x01: parity bit=1. LCR=0x0B (8O1), write 0x01: parity=0. LCR=0x3B (stick), write 0x01: parity=0.
- FifoEn=1, 17 writes in consecutive cycles while idle:
  - The first byte pops, so the count peaks at 16 and TXRDYb=1.
  - The 17th write is kept (it fits after the pop), and bytes transmit back-to-back with no idle between stop and start.
- FifoEn=1, 20 writes with the divisor large:
  - The last writes are dropped once the count is 16.
  - TxFifoReset mid-character: count=0 and THRE=1 next cycle; the current character completes, then SOUT idles high.
- LCR=0x04 (5-bit, STB=1), write 0x1F: 5 data bits, then exactly 32 cycles of stop at divisor 1. Set LCR[6] mid-data: SOUT=0 until it clears.
- With UART_TX_CTS_FLOW_EN, CTSb=1, write 0xA5: SOUT stays 1 and TEMT=0. Drive CTSb=0: the start bit appears 1 cycle later.
